beat_freq_gen: RTL

//  Programmable tempo generator: divides clk_100mhz down to a beat-rate square wave BF_out.
//  BF_out feeds the beat-pattern stage's BF_120BPM clock input.

---
 rtl/beat_freq_gen.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/beat_freq_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : beat_freq_gen
// Purpose  : Programmable tempo generator. Divides clk_100mhz down to a
//            beat-rate square wave (BF_out). The tempo is given in BPM and
//            converted to a cycle period by an iterative restoring divider.
//            A new period is adopted only at a beat boundary, so downstream
//            logic never sees a runt pulse.
// Ports    : clk_100mhz  system clock, all logic on posedge
//            rst         asynchronous active-high reset
//            run         1 = generate beats, 0 = stop (BF_out low)
//            bpm         requested tempo, sampled with bpm_load
//            bpm_load    1-cycle strobe starting a period computation
//            BF_out      beat square wave, high for floor(P/2) of P cycles
//            bf_tick     1-cycle strobe on each beat start
//            beat_cnt    beats since run rose (wraps 255 -> 0)
//            busy        divider computing
//            bpm_err     sticky flag: a bpm==0 load was rejected
//            sync        phase realign strobe (SYNC_IN_EN builds only)
// Options  : SYNC_IN_EN  adds the sync input
// Revision : 1.0  initial release
// ============================================================================
module beat_freq_gen #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BPM_W       = 8,
    parameter int DEFAULT_BPM = 120,
    parameter int PER_W       = 33
) (
    input  logic             clk_100mhz,
    input  logic             rst,
    input  logic             run,
    input  logic [BPM_W-1:0] bpm,
    input  logic             bpm_load,
    output logic             BF_out,
    output logic             bf_tick,
    output logic [7:0]       beat_cnt,
    output logic             busy,
    output logic             bpm_err
`ifdef SYNC_IN_EN
    ,
    input  logic             sync
`endif
);

    // Cycles per minute; 64-bit so the product cannot overflow at elaboration.
    localparam logic [63:0]      c_DIVIDEND_64 = 64'(CLK_HZ) * 64'd60;
    localparam logic [PER_W-1:0] c_DIVIDEND    = c_DIVIDEND_64[PER_W-1:0];
    localparam logic [PER_W-1:0] c_DEFAULT_PER = PER_W'(c_DIVIDEND_64 / 64'(DEFAULT_BPM));
    localparam int               c_CNT_W       = $clog2(PER_W);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(PER_W - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_DIV  = 1'b1;

    // ------------------------------------------------------------------
    // Divider state
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [BPM_W-1:0]   r_div;
    logic [BPM_W-1:0]   r_rem;
    logic [PER_W-1:0]   r_quo;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;
    logic [PER_W-1:0]   r_pnext;
    logic               r_pending;

    // ------------------------------------------------------------------
    // Beat generator state
    // ------------------------------------------------------------------
    logic               r_active;
    logic [PER_W-1:0]   r_ph;
    logic [PER_W-1:0]   r_per;
    logic [7:0]         r_beat;
    logic               r_bf;
    logic               r_tick;

    logic               w_sync;
    logic [BPM_W:0]     w_rem_sh;
    logic               w_ge;
    logic [BPM_W-1:0]   w_rem_nxt;
    logic [PER_W-1:0]   w_quo_nxt;
    logic               w_div_done;
    logic [PER_W:0]     w_ph_inc;
    logic               w_wrap;
    logic               w_active_nxt;
    logic [PER_W-1:0]   w_ph_nxt;
    logic [7:0]         w_beat_nxt;
    logic               w_boundary;
    logic [PER_W-1:0]   w_per_nxt;

`ifdef SYNC_IN_EN
    assign w_sync = sync;
`else
    assign w_sync = 1'b0;
`endif

    // One restoring-division step: the dividend shifts out of r_quo MSB-first
    // into the partial remainder while quotient bits shift in at the bottom.
    // The remainder always stays below the divisor, so the subtraction can be
    // done at BPM_W bits once the compare has decided.
    assign w_rem_sh   = {r_rem, r_quo[PER_W-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_div});
    assign w_rem_nxt  = w_ge ? (w_rem_sh[BPM_W-1:0] - r_div) : w_rem_sh[BPM_W-1:0];
    assign w_quo_nxt  = {r_quo[PER_W-2:0], w_ge};
    assign w_div_done = (r_state == c_ST_DIV) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_div   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bpm_load) begin
                        if (bpm == '0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err   <= 1'b0;
                            r_div   <= bpm;
                            r_rem   <= '0;
                            r_quo   <= c_DIVIDEND;
                            r_cnt   <= '0;
                            r_state <= c_ST_DIV;
                        end
                    end
                end
                c_ST_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Beat sequencing. w_boundary marks every point where a new beat starts
    // (run rise, natural wrap, accepted sync) and is the only place a
    // pending period is adopted.
    // ------------------------------------------------------------------
    // "ph+1 >= P" rather than "ph == P-1" keeps the counter bounded even if
    // a degenerate period of 0 were ever computed.
    assign w_ph_inc = {1'b0, r_ph} + (PER_W + 1)'(1);
    assign w_wrap   = (w_ph_inc >= {1'b0, r_per});

    always_comb begin
        w_active_nxt = r_active;
        w_ph_nxt     = r_ph;
        w_beat_nxt   = r_beat;
        w_boundary   = 1'b0;
        if (!run) begin
            w_active_nxt = 1'b0;
            w_ph_nxt     = '0;
        end else if (!r_active) begin
            w_active_nxt = 1'b1;
            w_ph_nxt     = '0;
            w_beat_nxt   = '0;
            w_boundary   = 1'b1;
        end else if (w_wrap) begin
            w_ph_nxt     = '0;
            w_beat_nxt   = r_beat + 8'd1;
            w_boundary   = 1'b1;
        end else if (w_sync && (r_ph != '0)) begin
            w_ph_nxt     = '0;
            w_beat_nxt   = r_beat + 8'd1;
            w_boundary   = 1'b1;
        end else begin
            w_ph_nxt     = w_ph_inc[PER_W-1:0];
        end
    end

    assign w_per_nxt = (w_boundary && r_pending) ? r_pnext : r_per;

    // A divide finishing on a boundary cycle keeps pending set: the older
    // Pnext is consumed now and the fresh one waits for the next boundary.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_pnext   <= c_DEFAULT_PER;
            r_pending <= 1'b0;
        end else if (w_div_done) begin
            r_pnext   <= w_quo_nxt;
            r_pending <= 1'b1;
        end else if (w_boundary) begin
            r_pending <= 1'b0;
        end
    end

    // Outputs are registered from next-state values so BF_out is glitch-free
    // and usable as a clock by the beat-pattern stage.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_ph     <= '0;
            r_per    <= c_DEFAULT_PER;
            r_beat   <= '0;
            r_bf     <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_active <= w_active_nxt;
            r_ph     <= w_ph_nxt;
            r_per    <= w_per_nxt;
            r_beat   <= w_beat_nxt;
            r_bf     <= w_active_nxt && (w_ph_nxt < (w_per_nxt >> 1));
            r_tick   <= w_active_nxt && (w_ph_nxt == '0);
        end
    end

    assign BF_out   = r_bf;
    assign bf_tick  = r_tick;
    assign beat_cnt = r_beat;
    assign busy     = (r_state == c_ST_DIV);
    assign bpm_err  = r_err;

endmodule
`default_nettype wire
